// File: rtl/nios_system_nios2_qsys_0_mulx_seq_if.sv
// Request/response bundle for the sequential 32x32 multiplier.
// The master issues operations and consumes results; the slave is the multiplier.
interface nios_system_nios2_qsys_0_mulx_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        busy;

    modport master (
        output req_valid, req_op, req_src1, req_src2, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, busy
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, rsp_ready,
        output req_ready, rsp_valid, rsp_result, busy
    );
endinterface

// File: rtl/nios_system_nios2_qsys_0_mulx_seq.sv
// Sequential 32x32 multiplier built from one time-shared 16x16 unsigned multiplier.
// Produces the low word (mul) or the high word (mulxuu/mulxsu/mulxss).
module nios_system_nios2_qsys_0_mulx_seq #(
    parameter int unsigned EARLY_MUL = 1
) (
    input  logic clk,
    input  logic reset,
    nios_system_nios2_qsys_0_mulx_seq_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PP0  = 3'd1,
        ST_PP1  = 3'd2,
        ST_PP2  = 3'd3,
        ST_PP3  = 3'd4,
        ST_FIX  = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] src1_r;
    logic [31:0] src2_r;
    logic [1:0]  op_r;
    logic [63:0] acc_r;
    logic [31:0] result_r;
    logic [31:0] result_nxt_s;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic        busy_r;
    logic [15:0] mul_a_s;
    logic [15:0] mul_b_s;
    logic [31:0] prod_s;
    logic [63:0] pp_s;
    logic [63:0] acc_sum_s;

    // Signed correction of the unsigned high word: subtract the operand
    // weighted by the other operand's sign bit when that operand is signed.
    function automatic logic [31:0] fix_hi(
        input logic [31:0] hi,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [1:0]  op
    );
        logic [31:0] corr_a;
        logic [31:0] corr_b;
        corr_a = (a[31] && op[1]) ? b : 32'd0;
        corr_b = (b[31] && (op == 2'b11)) ? a : 32'd0;
        return hi - corr_a - corr_b;
    endfunction

    // Operand halves fed to the shared multiplier in each partial-product state.
    always_comb begin
        mul_a_s = src1_r[15:0];
        mul_b_s = src2_r[15:0];
        case (state_r)
            ST_PP1: begin
                mul_a_s = src1_r[31:16];
                mul_b_s = src2_r[15:0];
            end
            ST_PP2: begin
                mul_a_s = src1_r[15:0];
                mul_b_s = src2_r[31:16];
            end
            ST_PP3: begin
                mul_a_s = src1_r[31:16];
                mul_b_s = src2_r[31:16];
            end
            default: begin
                mul_a_s = src1_r[15:0];
                mul_b_s = src2_r[15:0];
            end
        endcase
    end

    assign prod_s = {16'd0, mul_a_s} * {16'd0, mul_b_s};

    // Align the partial product to its weight in the 64-bit accumulator.
    always_comb begin
        pp_s = 64'd0;
        case (state_r)
            ST_PP0:          pp_s = {32'd0, prod_s};
            ST_PP1, ST_PP2:  pp_s = {16'd0, prod_s, 16'd0};
            ST_PP3:          pp_s = {prod_s, 32'd0};
            default:         pp_s = 64'd0;
        endcase
    end

    assign acc_sum_s = acc_r + pp_s;

    // Next-state and next-result selection.
    always_comb begin
        state_nxt_s  = state_r;
        result_nxt_s = result_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_nxt_s = ST_PP0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PP0: state_nxt_s = ST_PP1;
            ST_PP1: state_nxt_s = ST_PP2;
            ST_PP2: begin
                // The low word is complete once aH*bH (weight 2^32) is all that remains.
                if ((op_r == 2'b00) && (EARLY_MUL != 32'd0)) begin
                    state_nxt_s  = ST_DONE;
                    result_nxt_s = acc_sum_s[31:0];
                end else begin
                    state_nxt_s = ST_PP3;
                end
            end
            ST_PP3: state_nxt_s = ST_FIX;
            ST_FIX: begin
                state_nxt_s = ST_DONE;
                if (op_r == 2'b00) begin
                    result_nxt_s = acc_r[31:0];
                end else begin
                    result_nxt_s = fix_hi(acc_r[63:32], src1_r, src2_r, op_r);
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Controller state, operand capture, accumulation and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            src1_r      <= 32'd0;
            src2_r      <= 32'd0;
            op_r        <= 2'b00;
            acc_r       <= 64'd0;
            result_r    <= 32'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            result_r    <= result_nxt_s;
            req_ready_r <= (state_nxt_s == ST_IDLE);
            rsp_valid_r <= (state_nxt_s == ST_DONE);
            busy_r      <= (state_nxt_s != ST_IDLE);
            if ((state_r == ST_IDLE) && bus.req_valid) begin
                src1_r <= bus.req_src1;
                src2_r <= bus.req_src2;
                op_r   <= bus.req_op;
                acc_r  <= 64'd0;
            end else if ((state_r == ST_PP0) || (state_r == ST_PP1) ||
                         (state_r == ST_PP2) || (state_r == ST_PP3)) begin
                acc_r <= acc_sum_s;
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_result = result_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_nios_system_nios2_qsys_0_mulx_seq.sv
// Randomized bench: two multipliers (EARLY_MUL = 1 and 0) driven in lockstep and
// checked against a 64-bit arithmetic reference for results and latency.
module tb_nios_system_nios2_qsys_0_mulx_seq;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    nios_system_nios2_qsys_0_mulx_seq_if bus0 ();
    nios_system_nios2_qsys_0_mulx_seq_if bus1 ();

    nios_system_nios2_qsys_0_mulx_seq #(.EARLY_MUL(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    nios_system_nios2_qsys_0_mulx_seq #(.EARLY_MUL(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: sign/zero-extend to 64 bits and multiply modulo 2^64.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa;
        logic [63:0] xb;
        logic [63:0] p;
        xa = op[1] ? {{32{a[31]}}, a} : {32'd0, a};
        xb = (op == 2'b11) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = xa * xb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus0.req_valid = v; bus0.req_op = op; bus0.req_src1 = a; bus0.req_src2 = b;
        bus1.req_valid = v; bus1.req_op = op; bus1.req_src1 = a; bus1.req_src2 = b;
    endtask

    task automatic set_rsp_ready(input logic r);
        bus0.rsp_ready = r;
        bus1.rsp_ready = r;
    endtask

    // Called just after an accept edge with rsp_ready high; records first response of each DUT.
    task automatic run_resp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp;
        logic [31:0] r0;
        logic [31:0] r1;
        int g0;
        int g1;
        exp = ref_mul(op, a, b);
        r0 = 32'd0; r1 = 32'd0; g0 = 0; g1 = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (bus0.rsp_valid && (g0 == 0)) begin g0 = k; r0 = bus0.rsp_result; end
            if (bus1.rsp_valid && (g1 == 0)) begin g1 = k; r1 = bus1.rsp_result; end
        end
        chk({tag, "_res_e1"}, r0, exp);
        chk({tag, "_res_e0"}, r1, exp);
        chk({tag, "_lat_e1"}, g0, (op == 2'b00) ? 32'd3 : 32'd5);
        chk({tag, "_lat_e0"}, g1, 32'd5);
        chk({tag, "_idle_e1"}, {31'd0, bus0.req_ready}, 32'd1);
        chk({tag, "_idle_e0"}, {31'd0, bus1.req_ready}, 32'd1);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        set_rsp_ready(1'b1);
        drive(1'b1, op, a, b);
        @(posedge clk); #1;
        // Operands become don't-care after the accept edge.
        drive(1'b0, 2'($urandom), $urandom, $urandom);
        chk({tag, "_busy"}, {30'd0, bus0.busy, bus1.busy}, 32'd3);
        run_resp(op, a, b, tag);
    endtask

    logic [31:0] corner [4];
    logic [31:0] held;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    int          seen;

    initial begin
        corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000; corner[3] = 32'h7FFF_FFFF;
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        set_rsp_ready(1'b1);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_ready", {30'd0, bus0.req_ready, bus1.req_ready}, 32'd3);
        chk("rst_valid", {30'd0, bus0.rsp_valid, bus1.rsp_valid}, 32'd0);
        chk("rst_busy",  {30'd0, bus0.busy, bus1.busy}, 32'd0);
        chk("rst_result", bus0.rsp_result | bus1.rsp_result, 32'd0);

        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "uu_ff");
        do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "ss_ff");
        do_op(2'b11, 32'h8000_0000, 32'h8000_0000, "ss_80");
        do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "su_ff");
        do_op(2'b10, 32'h0000_0002, 32'h8000_0000, "su_2x80");
        do_op(2'b00, 32'h0001_0001, 32'h0001_0001, "mul_10001");

        // Backpressure: hold the response, keep a second request pending.
        set_rsp_ready(1'b0);
        drive(1'b1, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
        @(posedge clk); #1;
        drive(1'b1, 2'b01, 32'hDEAD_BEEF, 32'h0000_1000);
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            @(posedge clk); #1;
            if (bus0.rsp_valid) seen = 1;
        end
        chk("bp_seen", seen, 32'd1);
        held = bus0.rsp_result;
        chk("bp_res", held, ref_mul(2'b11, 32'h1234_5678, 32'h9ABC_DEF0));
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("bp_hold", bus0.rsp_result, held);
            chk("bp_flags", {29'd0, bus0.rsp_valid, bus0.req_ready, bus1.rsp_valid}, 32'd5);
        end
        chk("bp_res_e0", bus1.rsp_result, held);
        set_rsp_ready(1'b1);
        @(posedge clk); #1;
        chk("bp_release", {28'd0, bus0.req_ready, bus1.req_ready, bus0.rsp_valid, bus1.rsp_valid}, 32'd12);
        @(posedge clk); #1;
        drive(1'b0, 2'b00, $urandom, $urandom);
        chk("bp_second_acc", {30'd0, bus0.busy, bus1.busy}, 32'd3);
        run_resp(2'b01, 32'hDEAD_BEEF, 32'h0000_1000, "bp_second");

        // Reset in PP2 of an op 01 request discards it.
        drive(1'b1, 2'b01, 32'hCAFE_F00D, 32'h1357_9BDF);
        @(posedge clk); #1;
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_ready", {30'd0, bus0.req_ready, bus1.req_ready}, 32'd3);
        chk("mid_rst_valid", {30'd0, bus0.rsp_valid, bus1.rsp_valid}, 32'd0);
        chk("mid_rst_result", bus0.rsp_result | bus1.rsp_result, 32'd0);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus0.rsp_valid || bus1.rsp_valid || bus0.busy || bus1.busy) seen = 1;
        end
        chk("mid_rst_stale", seen, 32'd0);
        do_op(2'b01, 32'h0BAD_F00D, 32'hFEED_FACE, "after_rst");

        // Random traffic with corner operands mixed in.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            do_op(rop, ra, rb, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nios_system_nios2_qsys_0_mulx_seq.md
NIOS_SYSTEM_NIOS2_QSYS_0_MULX_SEQ -- requirements
Module: nios_system_nios2_qsys_0_mulx_seq

Interface
REQ-001 SHALL have one parameter: EARLY_MUL, default 1; when 1, op 00 (low word) skips the hi*hi partial product and the sign-fix state.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-005 SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 SHALL have port req_op, input, 2 bits: operation select. 00 = mul (low 32 bits); 01 = mulxuu; 10 = mulxsu (src1 signed, src2 unsigned); 11 = mulxss. Ops 01/10/11 return the high 32 bits.
REQ-007 SHALL have ports req_src1 and req_src2, inputs, 32 bits each: the operands.
REQ-008 SHALL have port rsp_valid, output, 1 bit: rsp_result is valid.
REQ-009 SHALL have port rsp_ready, input, 1 bit: the consumer takes the result.
REQ-010 SHALL have port rsp_result, output, 32 bits: the selected result word.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL implement the states IDLE, PP0, PP1, PP2, PP3, FIX and DONE.
REQ-013 SHALL drive req_ready = (state == IDLE).
REQ-014 Accept SHALL occur when req_valid & req_ready; at that edge the block latches src1, src2 and op, clears the 64-bit accumulator, and moves to PP0.
REQ-015 Each PPn state SHALL add one 16x16 unsigned partial product, shifted, into the 64-bit unsigned accumulator:
  - PP0: aL*bL << 0
  - PP1: aH*bL << 16
  - PP2: aL*bH << 16
  - PP3: aH*bH << 32
REQ-016 The datapath SHALL use exactly one 16x16 multiplier, time-shared across the PPn states.
REQ-017 Transitions SHALL be PP0->PP1->PP2, then as follows:
  - PP2->PP3 for ops 01/10/11, or for op 00 when EARLY_MUL = 0.
  - PP2->DONE for op 00 when EARLY_MUL = 1.
  - PP3->FIX->DONE.
REQ-018 FIX SHALL compute hi = acc[63:32] - (a[31] & op is 10 or 11 ? b : 0) - (b[31] & op is 11 ? a : 0), modulo 2^32.
REQ-019 FIX SHALL pass op 01 through unchanged, and op 00 SHALL take acc[31:0].
REQ-020 rsp_result SHALL be registered and loaded on entry to DONE.
REQ-021 rsp_valid SHALL be 1 exactly while in DONE.
REQ-022 Latency: rsp_valid SHALL rise 5 edges after the accept edge for ops 01/10/11 or op 00 with EARLY_MUL = 0, and 3 edges after the accept edge for op 00 with EARLY_MUL = 1.
REQ-023 In DONE with rsp_ready = 0, rsp_result and rsp_valid SHALL hold indefinitely.
REQ-024 When rsp_valid & rsp_ready, the block SHALL move to IDLE, so req_ready is high in the next cycle; a new request SHALL NOT be accepted in the same cycle as the response handshake.
REQ-025 Requests presented while busy SHALL be ignored (not latched) and SHALL remain pending until req_ready.
REQ-026 Operand inputs SHALL be don't-care after the accept edge; changes to them SHALL NOT affect the in-flight result.
REQ-027 All arithmetic SHALL be modulo its stated width, with no overflow flags.

Reset
REQ-028 reset = 1 at a clock edge SHALL force state IDLE, rsp_valid = 0, rsp_result = 0x00000000, accumulator = 0 and busy = 0.
REQ-029 reset SHALL take priority over any handshake in the same cycle.
REQ-030 reset asserted mid-operation SHALL discard the in-flight result, with no response ever issued for it.
REQ-031 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-032 op 01, src1 = src2 = 0xFFFFFFFF -> rsp_result 0xFFFFFFFE, rsp_valid 5 edges after accept.
REQ-033 op 11, src1 = src2 = 0xFFFFFFFF -> 0x00000000; op 11, src1 = src2 = 0x80000000 -> 0x40000000.
REQ-034 op 10, src1 = src2 = 0xFFFFFFFF -> 0xFFFFFFFF; op 10, src1 = 0x00000002, src2 = 0x80000000 -> 0x00000001.
REQ-035 op 00, src1 = src2 = 0x00010001, EARLY_MUL = 1 -> 0x00020001 after 3 edges; the same with EARLY_MUL = 0 -> 0x00020001 after 5 edges.
REQ-036 Backpressure: hold rsp_ready = 0 for 10 cycles in DONE -> rsp_result stable, req_ready = 0, and a second req_valid is not accepted; raise rsp_ready -> IDLE next cycle, then the second request is accepted.
REQ-037 Reset in PP2 of an op 01 request -> next cycle IDLE, rsp_valid = 0, rsp_result = 0; a following request completes with the correct value and no stale response.
